// File: rtl/latch_load_if.sv
// latch_load_if: start/serial-data/abort request side and latch d/en status side of the load sequencer
interface latch_load_if #(parameter int WIDTH = 8);
  logic start;
  logic sdi;
  logic abort;
  logic [WIDTH-1:0] d;
  logic en;
  logic busy;
  logic done;
  modport master (output start, sdi, abort, input d, en, busy, done);
  modport slave (input start, sdi, abort, output d, en, busy, done);
endinterface

// File: rtl/latch_load_seq.sv
// latch_load_seq: shifts a serial word in, then pulses the latch enable with setup/hold margins around a stable d
module latch_load_seq #(
  parameter int WIDTH = 8,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC = 2,
  parameter int HOLD_CYC = 1
) (
  input logic clk,
  input logic rst_n,
  latch_load_if.slave bus
);
  localparam int M1 = WIDTH > SETUP_CYC ? WIDTH : SETUP_CYC;
  localparam int M2 = EN_CYC > HOLD_CYC ? EN_CYC : HOLD_CYC;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, SETUP, EN, HOLD} state_t;
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [WIDTH-2:0] r_sr, w_sr;
  logic [WIDTH-1:0] r_d, w_d, w_word;
  logic r_en, w_en, r_busy, w_busy, r_done, w_done, w_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_sr <= '0;
      r_d <= '0;
      r_en <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_sr <= w_sr;
      r_d <= w_d;
      r_en <= w_en;
      r_busy <= w_busy;
      r_done <= w_done;
    end
  end
  // each state's counter is loaded on entry and the transition fires when it reaches 1
  always_comb begin
    w_word = {r_sr, bus.sdi};
    w_last = r_cnt == CW'(1);
    w_state = r_state;
    w_cnt = r_cnt;
    w_sr = r_sr;
    w_d = r_d;
    w_en = r_en;
    w_busy = r_busy;
    w_done = 1'b0;
    if (r_state != IDLE && bus.abort) begin
      w_state = IDLE;
      w_cnt = '0;
      w_en = 1'b0;
      w_busy = 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          w_state = SHIFT;
          w_cnt = CW'(WIDTH);
          w_busy = 1'b1;
        end
        SHIFT: begin
          w_sr = w_word[WIDTH-2:0];
          w_cnt = r_cnt - CW'(1);
          if (w_last) begin
            w_d = w_word;
            w_state = SETUP;
            w_cnt = CW'(SETUP_CYC);
          end
        end
        SETUP: begin
          w_cnt = r_cnt - CW'(1);
          if (w_last) begin
            w_state = EN;
            w_en = 1'b1;
            w_cnt = CW'(EN_CYC);
          end
        end
        EN: begin
          w_cnt = r_cnt - CW'(1);
          if (w_last) begin
            w_state = HOLD;
            w_en = 1'b0;
            w_cnt = CW'(HOLD_CYC);
          end
        end
        HOLD: begin
          w_cnt = r_cnt - CW'(1);
          if (w_last) begin
            w_state = IDLE;
            w_busy = 1'b0;
            w_done = 1'b1;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end
  assign bus.d = r_d;
  assign bus.en = r_en;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_latch_load_seq.sv
// tb_latch_load_seq: directed load/abort/reset sequence with a word scoreboard popped on each done pulse
module tb_latch_load_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int n_done = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prev_d = '0;
  logic prev_en = 1'b0;
  logic prev_rst = 1'b0;
  latch_load_if #(.WIDTH(8)) b0();
  latch_load_if #(.WIDTH(4)) b1();
  latch_load_seq #(.WIDTH(8), .SETUP_CYC(1), .EN_CYC(2), .HOLD_CYC(1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  latch_load_seq #(.WIDTH(4), .SETUP_CYC(3), .EN_CYC(1), .HOLD_CYC(2))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  always @(negedge clk) begin
    if (rst_n && prev_rst && b0.d !== prev_d)
      check("d_change_en_low", {30'd0, prev_en, b0.en}, 32'd0);
    if (rst_n && b0.done) begin
      n_done++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_word", b0.d, exp_q.pop_front());
    end
    prev_d = b0.d;
    prev_en = b0.en;
    prev_rst = rst_n;
  end
  task automatic shift_word(input logic [7:0] w, input bit ign);
    logic [7:0] old;
    old = b0.d;
    b0.start = 1'b1;
    tick();
    check("busy_start", b0.busy, 1);
    check("done_drop", b0.done, 0);
    for (int i = 7; i >= 0; i--) begin
      b0.start = ign && i == 4;
      b0.sdi = w[i];
      tick();
      if (i > 0) check("d_stable_shift", b0.d, old);
    end
    b0.start = 1'b0;
    check("d_word", b0.d, w);
    check("en_setup", b0.en, 0);
  endtask
  task automatic finish_word(input logic [7:0] w, input bit ign, input bit chain);
    exp_q.push_back(w);
    tick();
    check("en_rise", b0.en, 1);
    b0.start = ign;
    tick();
    b0.start = 1'b0;
    check("en_high2", b0.en, 1);
    check("busy_en", b0.busy, 1);
    b0.start = chain;
    tick();
    check("en_fall", b0.en, 0);
    check("busy_hold", b0.busy, 1);
    check("d_hold", b0.d, w);
    check("done_early", b0.done, 0);
    tick();
    check("done_pulse", b0.done, 1);
    check("busy_done", b0.busy, 0);
    check("en_done", b0.en, 0);
  endtask
  initial begin
    logic [7:0] old;
    logic [3:0] w1;
    int nd;
    b0.start = 0; b0.sdi = 0; b0.abort = 0;
    b1.start = 0; b1.sdi = 0; b1.abort = 0;
    tick();
    tick();
    check("rst_d", b0.d, 0);
    check("rst_en", b0.en, 0);
    check("rst_busy", b0.busy, 0);
    check("rst_done", b0.done, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_busy", b0.busy, 0);
    // basic A5 load, start held through its done cycle so 3C follows with no gap
    shift_word(8'hA5, 1'b0);
    finish_word(8'hA5, 1'b0, 1'b1);
    shift_word(8'h3C, 1'b0);
    finish_word(8'h3C, 1'b0, 1'b0);
    tick();
    check("done_one_cycle", b0.done, 0);
    tick();
    // start pulses during SHIFT and EN must not add a load
    shift_word(8'h96, 1'b1);
    finish_word(8'h96, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    check("ign_idle", b0.busy, 0);
    check("ign_done_cnt", n_done, 3);
    // abort on the 5th SHIFT edge
    old = b0.d;
    nd = n_done;
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b0.sdi = 1'($urandom_range(1));
      tick();
    end
    b0.abort = 1'b1;
    tick();
    b0.abort = 1'b0;
    check("abs_busy", b0.busy, 0);
    check("abs_en", b0.en, 0);
    check("abs_d", b0.d, old);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abs_no_en", b0.en, 0);
    end
    check("abs_no_done", n_done, nd);
    // abort during EN
    shift_word(8'h5A, 1'b0);
    tick();
    check("abe_en", b0.en, 1);
    b0.abort = 1'b1;
    tick();
    b0.abort = 1'b0;
    check("abe_en_low", b0.en, 0);
    check("abe_busy", b0.busy, 0);
    for (int i = 0; i < 6; i++) tick();
    check("abe_no_done", n_done, nd);
    check("abe_d", b0.d, 8'h5A);
    // asynchronous reset while en is high
    shift_word(8'hC3, 1'b0);
    tick();
    check("rm_en_pre", b0.en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rm_en", b0.en, 0);
    check("rm_d", b0.d, 0);
    check("rm_busy", b0.busy, 0);
    check("rm_done", b0.done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("rm_idle", b0.busy, 0);
    check("rm_no_done", n_done, nd);
    // second instance: WIDTH=4, SETUP=3, EN=1, HOLD=2
    w1 = 4'h9;
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    check("sw_busy", b1.busy, 1);
    for (int e = 1; e <= 12; e++) begin
      if (e <= 4) b1.sdi = w1[4-e];
      tick();
      check("sw_en", b1.en, 32'(e == 7));
      check("sw_done", b1.done, 32'(e == 10));
      if (e == 4) check("sw_d", b1.d, w1);
    end
    check("sb_drained", exp_q.size(), 0);
    check("total_done", n_done, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/latch_load_seq.md
Name: latch_load_seq

Overview:
Upstream sequencer for the team's level-sensitive D-latch bank. It assembles a serial bit stream into a WIDTH-bit word and presents it on d. It then generates the latch enable with guaranteed setup and hold margins: d is stable before en rises, and stays stable after en falls. It runs in a single clock domain and drives the latch d/en inputs directly.

Parameters:
WIDTH, 8, bits per word shifted in and driven on d (>=2)
SETUP_CYC, 1, cycles d is stable with en low before en rises (>=1)
EN_CYC, 2, cycles en is held high (>=1)
HOLD_CYC, 1, cycles d is held stable with en low after en falls (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new load; sampled only in IDLE
sdi  input  1  serial data, MSB first, sampled in SHIFT
abort  input  1  synchronous cancel of an in-progress load
d  output  WIDTH  parallel data to the latch bank (registered)
en  output  1  latch enable (registered, high only in EN)
busy  output  1  high in SHIFT/SETUP/EN/HOLD
done  output  1  one-cycle pulse on completion of a load

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, d=0, en=0, busy=0, done=0, shift register=0, counter=0. Release is synchronous to the next edge; there is no other state.
- States: IDLE, SHIFT, SETUP, EN, HOLD. A single down-counter, sized for max(WIDTH, SETUP_CYC, EN_CYC, HOLD_CYC), times each state.
- IDLE: if start=1 at edge k, go to SHIFT. busy=1 from edge k. start in any other state is ignored and not queued.
- SHIFT: sdi is sampled on edges k+1..k+WIDTH, with sr <= {sr[WIDTH-2:0], sdi}. On edge k+WIDTH, d <= {sr[WIDTH-2:0], sdi} (the full word) and the state moves to SETUP. d changes only on this edge.
- SETUP: en=0 for SETUP_CYC cycles, then EN.
- EN: en=1 for exactly EN_CYC cycles. First high cycle follows edge k+WIDTH+SETUP_CYC. Then HOLD.
- HOLD: en=0, d unchanged, for HOLD_CYC cycles. Then IDLE with busy=0 and done=1 for exactly one cycle.
- Total latency: start at edge k gives done high in the cycle after edge k+WIDTH+SETUP_CYC+EN_CYC+HOLD_CYC.
- start=1 in the done cycle (state IDLE) is accepted normally. done drops on the next edge regardless.
- abort=1 in any non-IDLE state:
  - next edge: state=IDLE, en=0, busy=0, counter=0.
  - d is not updated (keeps its last value).
  - done is not pulsed.
- abort has priority over every transition, including the SHIFT->SETUP d update. abort in IDLE has no effect.
- If abort and start are both high in IDLE, start is accepted.
- en is never high while d is changing; d is never written while en=1 or during HOLD.
- Reset mid-operation forces en=0 immediately (asynchronously) and clears d.

Test Plan:
- Reset: rst_n=0 with en=1 mid-EN -> en, busy, done, d all 0 immediately without a clock; after release, idle until start.
- Basic load (WIDTH=8, S=1, E=2, H=1): start at edge 0, sdi=1,0,1,0,0,1,0,1 on edges 1-8 -> d=8'hA5 after edge 8; en=1 after edges 9-10; en=0 after edge 11; done=1 only after edge 12; busy=1 after edges 0-11.
- Back-to-back: start held high through the done cycle, second word 8'h3C -> second SHIFT begins with no gap; d switches A5->3C only after that load's 8th shift edge, never while en=1.
- Ignored start: pulse start during SHIFT and during EN -> no effect on timing, no extra load, exactly one done pulse.
- Abort: abort=1 on edge 5 of SHIFT -> IDLE next edge, d stays at the previous value, no en, no done. Abort during EN -> en=0 next edge, no done.
- Parameter sweep (WIDTH=4, S=3, E=1, H=2): start at edge 0 -> en high only after edge 7, done only after edge 10.
